// File: rtl/sn_rom_reader.sv
// sn_rom_reader: autonomous 1-Wire Read ROM sequencer for a DS2401-class serial-number chip.
// One start runs reset/presence, the 0x33 command and a CRC8-checked 64-bit ROM read.
module sn_rom_reader #(
  parameter int unsigned T_RSTL = 19200,
  parameter int unsigned T_PDS  = 2800,
  parameter int unsigned T_RSTH = 19200,
  parameter int unsigned T_W0L  = 2400,
  parameter int unsigned T_W1L  = 240,
  parameter int unsigned T_RL   = 240,
  parameter int unsigned T_RS   = 360,
  parameter int unsigned T_SLOT = 2800,
  parameter int unsigned CW     = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        sn_in,
  output logic        sn_out,
  output logic        busy,
  output logic        done,
  output logic        present,
  output logic        crc_ok,
  output logic [63:0] serial
);

  typedef enum logic [3:0] {
    IDLE, RST_LOW, RST_WAIT, RST_REC, TX_LOW, TX_REL, RX_LOW, RX_WAIT, RX_REC, FINISH
  } state_t;

  // Counter reload values: a phase of N cycles loads N-1 and ends when the counter reads 0.
  localparam logic [CW-1:0] LD_RSTL  = CW'(T_RSTL - 1);
  localparam logic [CW-1:0] LD_PDS   = CW'(T_PDS - 1);
  localparam logic [CW-1:0] LD_RSTH  = CW'(T_RSTH - T_PDS - 1);
  localparam logic [CW-1:0] LD_W0L   = CW'(T_W0L - 1);
  localparam logic [CW-1:0] LD_W1L   = CW'(T_W1L - 1);
  localparam logic [CW-1:0] LD_W0R   = CW'(T_SLOT - T_W0L - 1);
  localparam logic [CW-1:0] LD_W1R   = CW'(T_SLOT - T_W1L - 1);
  localparam logic [CW-1:0] LD_RL    = CW'(T_RL - 1);
  localparam logic [CW-1:0] LD_RS    = CW'(T_RS - 1);
  localparam logic [CW-1:0] LD_RXREC = CW'(T_SLOT - T_RL - T_RS - 1);
  localparam logic [7:0]    READ_ROM = 8'h33;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    idx_q, idx_d;
  logic [7:0]    crc_q, crc_d;
  logic [63:0]   serial_q, serial_d;
  logic          present_q, present_d;
  logic          crc_ok_q, crc_ok_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          sn_out_q, sn_out_d;
  logic          sn_meta_q, sn_s_q;

  logic phase_end, tx_bit, tx_next_bit, fb, finish;

  assign phase_end   = (cnt_q == '0);
  assign tx_bit      = READ_ROM[idx_q[2:0]];
  assign tx_next_bit = READ_ROM[idx_q[2:0] + 3'd1];
  assign fb          = sn_s_q ^ crc_q[0];

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    cnt_d     = phase_end ? cnt_q : cnt_q - 1'b1;
    idx_d     = idx_q;
    crc_d     = crc_q;
    serial_d  = serial_q;
    present_d = present_q;
    crc_ok_d  = crc_ok_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    sn_out_d  = sn_out_q;
    finish    = 1'b0;

    unique case (state_q)
      IDLE: begin
        sn_out_d = 1'b1;
        if (start) begin
          serial_d  = '0;
          present_d = 1'b0;
          crc_ok_d  = 1'b0;
          crc_d     = '0;
          busy_d    = 1'b1;
          sn_out_d  = 1'b0;
          cnt_d     = LD_RSTL;
          state_d   = RST_LOW;
        end
      end
      RST_LOW: if (phase_end) begin
        sn_out_d = 1'b1;
        cnt_d    = LD_PDS;
        state_d  = RST_WAIT;
      end
      RST_WAIT: if (phase_end) begin
        present_d = ~sn_s_q;
        cnt_d     = LD_RSTH;
        state_d   = RST_REC;
      end
      RST_REC: if (phase_end) begin
        if (!present_q) begin
          finish = 1'b1;
        end else begin
          idx_d    = '0;
          sn_out_d = 1'b0;
          cnt_d    = READ_ROM[0] ? LD_W1L : LD_W0L;
          state_d  = TX_LOW;
        end
      end
      TX_LOW: if (phase_end) begin
        sn_out_d = 1'b1;
        cnt_d    = tx_bit ? LD_W1R : LD_W0R;
        state_d  = TX_REL;
      end
      TX_REL: if (phase_end) begin
        sn_out_d = 1'b0;
        if (idx_q == 6'd7) begin
          idx_d   = '0;
          cnt_d   = LD_RL;
          state_d = RX_LOW;
        end else begin
          idx_d   = idx_q + 6'd1;
          cnt_d   = tx_next_bit ? LD_W1L : LD_W0L;
          state_d = TX_LOW;
        end
      end
      RX_LOW: if (phase_end) begin
        sn_out_d = 1'b1;
        cnt_d    = LD_RS;
        state_d  = RX_WAIT;
      end
      RX_WAIT: if (phase_end) begin
        serial_d = {sn_s_q, serial_q[63:1]};
        crc_d    = {fb, crc_q[7:5], crc_q[4] ^ fb, crc_q[3] ^ fb, crc_q[2:1]};
        cnt_d    = LD_RXREC;
        state_d  = RX_REC;
      end
      RX_REC: if (phase_end) begin
        if (idx_q == 6'd63) begin
          finish = 1'b1;
        end else begin
          idx_d    = idx_q + 6'd1;
          sn_out_d = 1'b0;
          cnt_d    = LD_RL;
          state_d  = RX_LOW;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Result flags are registered on entry so they are visible during the FINISH cycle.
    if (finish) begin
      state_d  = FINISH;
      sn_out_d = 1'b1;
      busy_d   = 1'b0;
      done_d   = 1'b1;
      crc_ok_d = present_q & (crc_q == 8'h00);
    end
  end

  // NOTE: sequential state uses non-blocking assignments; reset is synchronous and aborts at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      crc_q     <= '0;
      serial_q  <= '0;
      present_q <= 1'b0;
      crc_ok_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sn_out_q  <= 1'b1;
      sn_meta_q <= 1'b1;
      sn_s_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      crc_q     <= crc_d;
      serial_q  <= serial_d;
      present_q <= present_d;
      crc_ok_q  <= crc_ok_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sn_out_q  <= sn_out_d;
      sn_meta_q <= sn_in;
      sn_s_q    <= sn_meta_q;
    end
  end

  assign sn_out  = sn_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign present = present_q;
  assign crc_ok  = crc_ok_q;
  assign serial  = serial_q;

endmodule

// File: tb/tb_sn_rom_reader.sv
// Bench for sn_rom_reader: open-drain slave model, vector table with a result scoreboard,
// and hand-written sequences for FINISH/IDLE start handling and mid-read abort.
module tb_sn_rom_reader;

  localparam int T_RSTL = 40;
  localparam int T_PDS  = 12;
  localparam int T_RSTH = 40;
  localparam int T_W0L  = 10;
  localparam int T_W1L  = 2;
  localparam int T_RL   = 2;
  localparam int T_RS   = 3;
  localparam int T_SLOT = 14;
  localparam logic [63:0] GOOD_ROM = 64'hA2000000_01B81C02;

  typedef struct {
    string       name;
    logic        dev;
    logic [63:0] rom;
    logic        exp_present;
    logic        exp_crc_ok;
    logic [63:0] exp_serial;
  } vec_t;

  logic clk = 1'b0;
  logic rst, start, sn_in;
  logic sn_out, busy, done, present, crc_ok;
  logic [63:0] serial;

  logic        dev_present;
  logic [63:0] rom;
  logic        pres_pull, bit_pull;

  int cyc = 0;
  int done_cnt = 0;
  int n_checks = 0;
  int n_fail = 0;
  int low_w[$];
  int fall_c[$];
  vec_t sb_q[$];
  vec_t vecs[7];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Open-drain line: either side can pull it low.
  assign sn_in = sn_out & ~(pres_pull | bit_pull);

  sn_rom_reader #(
    .T_RSTL(T_RSTL), .T_PDS(T_PDS), .T_RSTH(T_RSTH), .T_W0L(T_W0L), .T_W1L(T_W1L),
    .T_RL(T_RL), .T_RS(T_RS), .T_SLOT(T_SLOT), .CW(15)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .sn_in(sn_in), .sn_out(sn_out),
    .busy(busy), .done(done), .present(present), .crc_ok(crc_ok), .serial(serial)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8_model(input logic [55:0] d);
    logic [7:0] c;
    logic [7:0] b;
    c = 8'h00;
    for (int i = 0; i < 7; i++) begin
      b = d[i*8 +: 8];
      for (int j = 0; j < 8; j++) begin
        if (c[0] ^ b[0]) c = (c >> 1) ^ 8'h8C;
        else             c = c >> 1;
        b = b >> 1;
      end
    end
    return c;
  endfunction

  function automatic logic [63:0] mk_rom(input logic [55:0] d);
    return {crc8_model(d), d};
  endfunction

  // Slave: presence from release+4 to release+19; a 0 bit holds the line low for 8 cycles.
  initial begin
    int low_run, pres_t, pull_left, slot;
    logic prev;
    low_run = 0; pres_t = -1; pull_left = 0; slot = 0; prev = 1'b1;
    pres_pull = 1'b0; bit_pull = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        low_run = 0; pres_t = -1; pull_left = 0; slot = 0; prev = 1'b1;
        pres_pull = 1'b0; bit_pull = 1'b0;
      end else begin
        if (prev && !sn_out) begin
          slot++;
          if (dev_present && slot >= 9 && slot <= 72 && !rom[slot-9]) pull_left = 8;
        end
        if (!prev && sn_out && low_run >= 20) begin
          slot   = 0;
          pres_t = dev_present ? 0 : -1;
        end
        low_run   = sn_out ? 0 : low_run + 1;
        prev      = sn_out;
        pres_pull = (pres_t >= 4 && pres_t < 20);
        if (pres_t >= 0) pres_t = (pres_t >= 20) ? -1 : pres_t + 1;
        bit_pull  = (pull_left > 0);
        if (pull_left > 0) pull_left--;
      end
    end
  end

  // Monitor: low-pulse widths, falling-edge times and done pulses.
  initial begin
    int run;
    logic prev;
    run = 0; prev = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (prev && !sn_out) fall_c.push_back(cyc);
      if (!prev && sn_out) low_w.push_back(run);
      run  = sn_out ? 0 : run + 1;
      prev = sn_out;
      if (done) done_cnt++;
    end
  end

  task automatic drive_start(input vec_t v, output int t_start);
    dev_present = v.dev;
    rom         = v.rom;
    @(negedge clk);
    start   = 1'b1;
    t_start = cyc;
    sb_q.push_back(v);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int t_done);
    vec_t e;
    bit got, busy_ok;
    got = 1'b0;
    busy_ok = busy;
    t_done = 0;
    for (int i = 0; i < 4000 && !got; i++) begin
      @(posedge clk); #1;
      if (done) begin
        got = 1'b1;
        t_done = cyc;
      end else if (!busy) begin
        busy_ok = 1'b0;
      end
    end
    check("busy held until done", 64'(busy_ok), 64'(1));
    check("done reached", 64'(got), 64'(1));
    if (got && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({e.name, " present"}, 64'(present), 64'(e.exp_present));
      check({e.name, " crc_ok"}, 64'(crc_ok), 64'(e.exp_crc_ok));
      check({e.name, " serial"}, serial, e.exp_serial);
      check({e.name, " busy low at done"}, 64'(busy), 64'(0));
    end
  endtask

  initial begin
    int exp_w[9];
    int t_start, t_done, dc0, n40;
    logic [55:0] rnd;

    rst = 1'b1; start = 1'b0; dev_present = 1'b0; rom = '0;
    exp_w = '{T_RSTL, T_W1L, T_W1L, T_W0L, T_W0L, T_W1L, T_W1L, T_W0L, T_W0L};
    rnd   = 56'({$urandom(), $urandom()});

    vecs[0] = '{"good_rom", 1'b1, GOOD_ROM, 1'b1, 1'b1, GOOD_ROM};
    vecs[1] = '{"corrupt_bit20", 1'b1, GOOD_ROM ^ (64'd1 << 20), 1'b1, 1'b0, GOOD_ROM ^ (64'd1 << 20)};
    vecs[2] = '{"no_device", 1'b0, GOOD_ROM, 1'b0, 1'b0, 64'd0};
    vecs[3] = '{"zero_rom", 1'b1, 64'd0, 1'b1, 1'b1, 64'd0};
    vecs[4] = '{"ones_rom", 1'b1, mk_rom({56{1'b1}}), 1'b1, 1'b1, mk_rom({56{1'b1}})};
    vecs[5] = '{"random_rom", 1'b1, mk_rom(rnd), 1'b1, 1'b1, mk_rom(rnd)};
    vecs[6] = '{"bad_crc_byte", 1'b1, mk_rom(rnd) ^ 64'h0100_0000_0000_0000, 1'b1, 1'b0,
                mk_rom(rnd) ^ 64'h0100_0000_0000_0000};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset serial", serial, 64'd0);
    check("reset flags {sn_out,busy,done,present,crc_ok}",
          64'({sn_out, busy, done, present, crc_ok}), 64'(5'b10000));

    foreach (vecs[k]) begin
      low_w.delete(); fall_c.delete(); dc0 = done_cnt;
      drive_start(vecs[k], t_start);
      wait_done(t_done);
      repeat (4) @(posedge clk);
      #1;
      check({vecs[k].name, " single done pulse"}, 64'(done_cnt - dc0), 64'(1));
      check({vecs[k].name, " serial held"}, serial, vecs[k].exp_serial);
      check({vecs[k].name, " reset low width"}, 64'(low_w.size() > 0 ? low_w[0] : -1), 64'(T_RSTL));
      if (vecs[k].dev) begin
        check({vecs[k].name, " low pulse count"}, 64'(low_w.size()), 64'(73));
        for (int i = 1; i < 9; i++) begin
          check($sformatf("%s tx width %0d", vecs[k].name, i - 1), 64'(low_w[i]), 64'(exp_w[i]));
          check($sformatf("%s tx slot %0d", vecs[k].name, i - 1),
                64'(fall_c[i+1] - fall_c[i]), 64'(T_SLOT));
        end
      end else begin
        check({vecs[k].name, " no tx slots"}, 64'(low_w.size()), 64'(1));
        check({vecs[k].name, " done latency"}, 64'(t_done - t_start), 64'(T_RSTL + T_RSTH + 1));
      end
    end

    // Start held through FINISH and the following IDLE cycle: only the IDLE one counts.
    drive_start(vecs[1], t_start);
    wait_done(t_done);
    start = 1'b1;
    sb_q.push_back(vecs[0]);
    dev_present = vecs[0].dev;
    rom = vecs[0].rom;
    @(posedge clk); #1;
    check("finish start ignored sn_out", 64'(sn_out), 64'(1));
    check("finish start ignored busy", 64'(busy), 64'(0));
    @(posedge clk); #1;
    start = 1'b0;
    check("idle start accepted sn_out", 64'(sn_out), 64'(0));
    check("idle start accepted busy", 64'(busy), 64'(1));
    wait_done(t_done);

    // Abort: start pulsed while busy, then reset during read bit 30.
    low_w.delete(); fall_c.delete(); dc0 = done_cnt;
    dev_present = 1'b1; rom = GOOD_ROM;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 3000 && fall_c.size() < 4; i++) @(posedge clk);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    check("busy-time start keeps busy", 64'(busy), 64'(1));
    for (int i = 0; i < 3000 && fall_c.size() < 1 + 8 + 31; i++) @(posedge clk);
    check("reached read bit 30", 64'(fall_c.size() >= 1 + 8 + 31), 64'(1));
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("abort sn_out released", 64'(sn_out), 64'(1));
    check("abort busy", 64'(busy), 64'(0));
    check("abort serial", serial, 64'd0);
    check("abort done", 64'(done), 64'(0));
    @(negedge clk); rst = 1'b0;
    n40 = 0;
    foreach (low_w[i]) if (low_w[i] == T_RSTL) n40++;
    check("busy-time start ignored", 64'(n40), 64'(1));
    repeat (100) @(posedge clk);
    #1;
    check("no done after abort", 64'(done_cnt - dc0), 64'(0));
    drive_start(vecs[0], t_start);
    wait_done(t_done);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
